// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers. Results are computed at the start edge,
// held in pending registers, and committed after a fixed per-operation busy latency.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_vld_q, pend_vld_d;

  // Sign-extending into 64 bits lets one unsigned multiplier serve MULT and MULTU.
  logic [63:0] ext_a, ext_b, prod;
  always_comb begin
    ext_a = {{32{(MDOp == OP_MULT) & A[31]}}, A};
    ext_b = {{32{(MDOp == OP_MULT) & B[31]}}, B};
    prod  = ext_a * ext_b;
  end

  // Signed divide via magnitudes so 0x80000000 / -1 needs no special case.
  logic        a_neg, b_neg;
  logic [31:0] ua, ub, ub_safe, uq, ur, quo, rem;
  always_comb begin
    a_neg   = (MDOp == OP_DIV) & A[31];
    b_neg   = (MDOp == OP_DIV) & B[31];
    ua      = a_neg ? -A : A;
    ub      = b_neg ? -B : B;
    ub_safe = (ub == 32'd0) ? 32'd1 : ub;
    uq      = ua / ub_safe;
    ur      = ua % ub_safe;
    quo     = (a_neg ^ b_neg) ? -uq : uq;
    rem     = a_neg ? -ur : ur;
  end

  logic done, accept;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    pend_vld_d = pend_vld_q;
    done       = (state_q == RUN) && (cnt_q == CW'(1));
    accept     = (state_q == IDLE) || done;

    if (state_q == RUN) begin
      if (done) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
        if (pend_vld_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    // A start coinciding with completion is applied after the commit, so MTHI/MTLO win.
    if (accept && Start) begin
      case (MDOp)
        OP_MULT, OP_MULTU: begin
          pend_hi_d  = prod[63:32];
          pend_lo_d  = prod[31:0];
          pend_vld_d = 1'b1;
          cnt_d      = CW'(MULT_CYCLES);
          state_d    = RUN;
          busy_d     = 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          pend_hi_d  = rem;
          pend_lo_d  = quo;
          pend_vld_d = (B != 32'd0);
          cnt_d      = CW'(DIV_CYCLES);
          state_d    = RUN;
          busy_d     = 1'b1;
        end
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      pend_hi_q  <= '0;
      pend_lo_q  <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  operation request, sampled at posedge.
REQ-006 SHALL have port MDOp  input  3  operation code, encoded as: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-007 SHALL have port A  input  32  rs operand (multiplicand/dividend/MT source).
REQ-008 SHALL have port B  input  32  rt operand (multiplier/divisor).
REQ-009 SHALL have port Busy  output  1  multi-cycle operation in progress.
REQ-010 SHALL have port HI  output  32  committed HI register, feeds HI_M of the M/W stage register.
REQ-011 SHALL have port LO  output  32  committed LO register, feeds LO_M of the M/W stage register.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and RUN, plus a down-counter sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-013 SHALL, in IDLE with Start=1 and MDOp in 0-3 at edge k, do all of the following:
- compute the full result from A and B;
- latch it into pending HI/LO registers;
- load the counter with the op latency N;
- enter RUN.
REQ-014 SHALL drive Busy=1 after edges k..k+N-1 and Busy=0 after edge k+N (Busy is registered, not combinational on Start).
REQ-015 SHALL copy the pending values to HI/LO at edge k+N and return to IDLE; HI/LO SHALL NOT change during RUN.
REQ-016 SHALL form MULT as the signed 64-bit product and MULTU as the unsigned 64-bit product, with HI=[63:32] and LO=[31:0].
REQ-017 SHALL compute DIV/DIVU as follows:
- LO=quotient, HI=remainder;
- DIV truncates toward zero and the remainder takes the sign of the dividend;
- DIVU is unsigned.
REQ-018 SHALL give DIV with A=0x80000000 and B=0xFFFFFFFF the results LO=0x80000000, HI=0x00000000.
REQ-019 SHALL, for divide by zero (B=0):
- still run the full DIV_CYCLES with Busy;
- leave HI/LO unchanged at completion.
REQ-020 SHALL, in IDLE with Start=1 and MDOp=4 (MTHI) or 5 (MTLO), write A into HI or LO respectively at that same edge, with no RUN and Busy staying 0.
REQ-021 SHALL ignore Start while Busy=1 (any MDOp, including MTHI/MTLO); the hazard unit stalls using Start|Busy.
REQ-022 SHALL accept a new Start at edge k+N, the same edge as completion:
- HI/LO commit the old result;
- the new op is latched;
- for mult/div, Busy stays 1;
- an MTHI/MTLO at that edge SHALL override the committed half.
REQ-023 SHALL treat MDOp 6-7 with Start=1 as a no-op with no state change.

Reset
REQ-024 SHALL, on reset=1 at any time, asynchronously force all of the following:
- FSM to IDLE, counter to 0, Busy=0;
- HI=0, LO=0, pending registers to 0.
REQ-025 SHALL abort an in-flight operation on reset without committing it, and SHALL accept Start on the first posedge after reset deasserts.

Verification
REQ-026 SHALL verify MULT: Start=1, MDOp=0, A=0xFFFFFFFE (-2), B=3 -> Busy high 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA; HI/LO unchanged while Busy.
REQ-027 SHALL verify DIV: A=0xFFFFFFF9 (-7), B=2, MDOp=2 -> after 10 cycles LO=0xFFFFFFFD and HI=0xFFFFFFFF; with MDOp=3 on the same operands -> LO=0x7FFFFFFC and HI=0x00000001.
REQ-028 SHALL verify divide by zero: HI=0x11111111 and LO=0x22222222 preloaded via MTHI/MTLO, then DIVU with B=0 -> Busy high 10 cycles, then HI/LO unchanged.
REQ-029 SHALL verify ignored starts: MULTU starts, then MTLO A=0xDEADBEEF is issued at cycle 2 of RUN -> LO ends as the product low word, not 0xDEADBEEF.
REQ-030 SHALL verify back-to-back operation: MULTU 0xFFFFFFFF x 0xFFFFFFFF, with a DIVU 100/7 issued at the completion edge -> HI=0xFFFFFFFE and LO=0x00000001 that cycle, Busy stays 1, then 10 cycles later HI=2 and LO=14.
REQ-031 SHALL verify reset mid-operation: reset asserted asynchronously at cycle 3 of DIV -> Busy, HI and LO become 0 immediately, with no later commit.
